// File: rtl/result_collector_pkg.sv
// Shared definitions for the result collector slice: default geometry of the
// assembled word and output FIFO, plus the width helpers that size the
// fill-level and bit-counter signals.
package result_collector_pkg;

    localparam int DEFAULT_WORD_WIDTH = 8;
    localparam int DEFAULT_FIFO_DEPTH = 4;

    // fill_level must represent 0..depth inclusive, hence one extra bit
    function automatic int fill_level_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Bit counter spans 0..word_width-1
    function automatic int bit_count_width(input int word_width);
        return (word_width <= 2) ? 1 : $clog2(word_width);
    endfunction

endpackage

// File: rtl/result_fifo.sv
// result_fifo: first-word-fall-through FIFO holding completed result words.
// A push into a full FIFO is accepted only when a pop happens on the same
// edge; otherwise the push is silently ignored (the caller flags overflow).
// Storage is not reset; head_data reads as zero whenever the FIFO is empty.
module result_fifo
    import result_collector_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_WORD_WIDTH,
    parameter int DEPTH      = DEFAULT_FIFO_DEPTH
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               push,
    input  logic [DATA_WIDTH-1:0]              push_data,
    input  logic                               pop,
    output logic [DATA_WIDTH-1:0]              head_data,
    output logic                               full,
    output logic                               empty,
    output logic [fill_level_width(DEPTH)-1:0] level
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LVL_W  = fill_level_width(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]     wr_ptr;
    logic [ADDR_W-1:0]     rd_ptr;
    logic [LVL_W-1:0]      count;
    logic                  do_pop;
    logic                  do_push;

    assign empty   = (count == '0);
    assign full    = (count == LVL_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointer and occupancy bookkeeping; pointers wrap by natural overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + LVL_W'(1);
                2'b01:   count <= count - LVL_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; on full push+pop the freed head slot is the one rewritten
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    assign head_data = empty ? '0 : mem[rd_ptr];
    assign level     = count;

endmodule

// File: rtl/result_collector.sv
// result_collector: assembles serial result bits (LSB first) into words of
// WORD_WIDTH bits and queues them in a first-word-fall-through FIFO.
// A flush emits a partially filled word zero-padded at the top. A completed
// word that cannot be queued is dropped and latches the sticky overflow flag.
// Optional feature macro: COLLECTOR_PARITY_EN adds a per-entry word_parity
// output (XOR of word_data) stored alongside each word.
module result_collector
    import result_collector_pkg::*;
#(
    parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    valid_bit,
    input  logic                                    output_bit,
    input  logic                                    flush,
    input  logic                                    clear_overflow,
    input  logic                                    word_ready,
    output logic                                    word_valid,
    output logic [WORD_WIDTH-1:0]                   word_data,
    output logic [fill_level_width(FIFO_DEPTH)-1:0] fill_level,
`ifdef COLLECTOR_PARITY_EN
    output logic                                    word_parity,
`endif
    output logic                                    overflow
);

    localparam int CNT_W = bit_count_width(WORD_WIDTH);
`ifdef COLLECTOR_PARITY_EN
    localparam int ENTRY_W = WORD_WIDTH + 1;
`else
    localparam int ENTRY_W = WORD_WIDTH;
`endif

    logic [WORD_WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0]      bit_cnt;
    logic [WORD_WIDTH-1:0] word_ins;
    logic                  complete;
    logic                  flush_push;
    logic                  push_req;
    logic                  pop;
    logic                  drop;
    logic [ENTRY_W-1:0]    fifo_in;
    logic [ENTRY_W-1:0]    fifo_head;
    logic                  fifo_full;
    logic                  fifo_empty;

    // Current word with this cycle's bit merged in, so flush sees it too
    always_comb begin
        word_ins = shift_reg;
        if (valid_bit) begin
            word_ins[bit_cnt] = output_bit;
        end
    end

    // Push decision: a completing bit pushes once; flush pushes a non-empty partial
    assign complete   = valid_bit && (bit_cnt == CNT_W'(WORD_WIDTH - 1));
    assign flush_push = flush && !complete && (valid_bit || (bit_cnt != '0));
    assign push_req   = complete || flush_push;

    assign pop  = !fifo_empty && word_ready;
    assign drop = push_req && fifo_full && !pop;

    // Bit assembly: accumulate until a push, then restart from an empty word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (push_req) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else if (valid_bit) begin
            shift_reg <= word_ins;
            bit_cnt   <= bit_cnt + CNT_W'(1);
        end
    end

    // Sticky overflow; a drop in the same cycle outranks a clear request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clear_overflow) begin
            overflow <= 1'b0;
        end
    end

`ifdef COLLECTOR_PARITY_EN
    assign fifo_in     = {^word_ins, word_ins};
    assign word_data   = fifo_head[WORD_WIDTH-1:0];
    assign word_parity = fifo_head[WORD_WIDTH];
`else
    assign fifo_in   = word_ins;
    assign word_data = fifo_head;
`endif

    assign word_valid = !fifo_empty;

    result_fifo #(
        .DATA_WIDTH (ENTRY_W),
        .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_req),
        .push_data  (fifo_in),
        .pop        (pop),
        .head_data  (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .level      (fill_level)
    );

endmodule

// File: tb/tb_result_collector.sv
// Directed testbench for result_collector (WORD_WIDTH=8, FIFO_DEPTH=4).
module tb_result_collector;

    logic       clk;
    logic       rst_n;
    logic       valid_bit;
    logic       output_bit;
    logic       flush;
    logic       clear_overflow;
    logic       word_ready;
    logic       word_valid;
    logic [7:0] word_data;
    logic [2:0] fill_level;
    logic       overflow;
`ifdef COLLECTOR_PARITY_EN
    logic       word_parity;
`endif

    int checks;
    int failures;

    result_collector #(
        .WORD_WIDTH (8),
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .valid_bit      (valid_bit),
        .output_bit     (output_bit),
        .flush          (flush),
        .clear_overflow (clear_overflow),
        .word_ready     (word_ready),
        .word_valid     (word_valid),
        .word_data      (word_data),
        .fill_level     (fill_level),
`ifdef COLLECTOR_PARITY_EN
        .word_parity    (word_parity),
`endif
        .overflow       (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        valid_bit  = 1'b1;
        output_bit = b;
        tick();
        valid_bit  = 1'b0;
        output_bit = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 0; i < 8; i++) send_bit(w[i]);
    endtask

    task automatic do_reset();
        valid_bit = 0; output_bit = 0; flush = 0; clear_overflow = 0; word_ready = 0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        valid_bit = 1; output_bit = 1; flush = 0; clear_overflow = 0; word_ready = 0;
        rst_n = 1'b0;
        tick(); tick(); tick();
        checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", word_valid); end
        checks++; if (word_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", word_data); end
        checks++; if (fill_level !== 3'd0) begin failures++; $display("FAIL reset_fill got=%0d exp=0", fill_level); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
        valid_bit = 0; output_bit = 0;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] pat;
        do_reset();
        word_ready = 1'b1;
        pat = 8'h4D;
        for (int i = 0; i < 7; i++) send_bit(pat[i]);
        checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b exp=0", word_valid); end
        send_bit(pat[7]);
        checks++; if (word_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", word_valid); end
        checks++; if (word_data !== 8'h4D) begin failures++; $display("FAIL basic_data got=%h exp=4d", word_data); end
`ifdef COLLECTOR_PARITY_EN
        checks++; if (word_parity !== 1'b0) begin failures++; $display("FAIL basic_parity got=%b exp=0", word_parity); end
`endif
        tick();
        checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL basic_pop_valid got=%b exp=0", word_valid); end
        checks++; if (fill_level !== 3'd0) begin failures++; $display("FAIL basic_pop_fill got=%0d exp=0", fill_level); end
        word_ready = 1'b0;
    endtask

    task automatic test_flush();
        do_reset();
        send_bit(1); send_bit(1); send_bit(1);
        checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL flush_pre_valid got=%b exp=0", word_valid); end
        flush = 1'b1; tick(); flush = 1'b0;
        checks++; if (fill_level !== 3'd1) begin failures++; $display("FAIL flush_fill got=%0d exp=1", fill_level); end
        checks++; if (word_data !== 8'h07) begin failures++; $display("FAIL flush_data got=%h exp=07", word_data); end
`ifdef COLLECTOR_PARITY_EN
        checks++; if (word_parity !== 1'b1) begin failures++; $display("FAIL flush_parity got=%b exp=1", word_parity); end
`endif
        flush = 1'b1; tick(); flush = 1'b0;
        checks++; if (fill_level !== 3'd1) begin failures++; $display("FAIL flush_empty_fill got=%0d exp=1", fill_level); end
        // Counter restarted: a full word after the flush lands aligned
        send_word(8'hA5);
        checks++; if (fill_level !== 3'd2) begin failures++; $display("FAIL flush_next_fill got=%0d exp=2", fill_level); end
        word_ready = 1'b1; tick(); word_ready = 1'b0;
        checks++; if (word_data !== 8'hA5) begin failures++; $display("FAIL flush_next_data got=%h exp=a5", word_data); end
    endtask

    task automatic test_flush_coincide();
        logic [7:0] pat;
        do_reset();
        pat = 8'h3C;
        for (int i = 0; i < 7; i++) send_bit(pat[i]);
        valid_bit = 1'b1; output_bit = pat[7]; flush = 1'b1;
        tick();
        valid_bit = 1'b0; flush = 1'b0;
        checks++; if (fill_level !== 3'd1) begin failures++; $display("FAIL coin_full_fill got=%0d exp=1", fill_level); end
        send_bit(1); send_bit(0);
        valid_bit = 1'b1; output_bit = 1'b1; flush = 1'b1;
        tick();
        valid_bit = 1'b0; output_bit = 1'b0; flush = 1'b0;
        checks++; if (fill_level !== 3'd2) begin failures++; $display("FAIL coin_part_fill got=%0d exp=2", fill_level); end
        checks++; if (word_data !== 8'h3C) begin failures++; $display("FAIL coin_head0 got=%h exp=3c", word_data); end
        word_ready = 1'b1; tick(); word_ready = 1'b0;
        checks++; if (word_data !== 8'h05) begin failures++; $display("FAIL coin_head1 got=%h exp=05", word_data); end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_w;
        do_reset();
        for (int w = 1; w <= 4; w++) send_word(8'(w));
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_pre got=%b exp=0", overflow); end
        send_word(8'h05);
        checks++; if (fill_level !== 3'd4) begin failures++; $display("FAIL ovf_fill got=%0d exp=4", fill_level); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        word_ready = 1'b1;
        for (int w = 1; w <= 4; w++) begin
            exp_w = 8'(w);
            checks++; if (word_data !== exp_w) begin failures++; $display("FAIL ovf_drain got=%h exp=%h", word_data, exp_w); end
            tick();
        end
        word_ready = 1'b0;
        checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL ovf_drained_valid got=%b exp=0", word_valid); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
        clear_overflow = 1'b1; tick(); clear_overflow = 1'b0;
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] pat;
        logic [7:0] exp_w;
        do_reset();
        send_word(8'h11); send_word(8'h22); send_word(8'h33); send_word(8'h44);
        pat = 8'h55;
        for (int i = 0; i < 7; i++) send_bit(pat[i]);
        valid_bit = 1'b1; output_bit = pat[7]; word_ready = 1'b1;
        tick();
        valid_bit = 1'b0; word_ready = 1'b0;
        checks++; if (fill_level !== 3'd4) begin failures++; $display("FAIL pp_fill got=%0d exp=4", fill_level); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL pp_ovf got=%b exp=0", overflow); end
        word_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            exp_w = 8'(k * 8'h11);
            checks++; if (word_data !== exp_w) begin failures++; $display("FAIL pp_drain got=%h exp=%h", word_data, exp_w); end
            tick();
        end
        word_ready = 1'b0;
    endtask

    task automatic test_set_wins();
        logic [7:0] pat;
        do_reset();
        for (int w = 1; w <= 4; w++) send_word(8'(w));
        pat = 8'h99;
        for (int i = 0; i < 7; i++) send_bit(pat[i]);
        valid_bit = 1'b1; output_bit = pat[7]; clear_overflow = 1'b1;
        tick();
        valid_bit = 1'b0; clear_overflow = 1'b0;
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL setwins_ovf got=%b exp=1", overflow); end
        checks++; if (word_data !== 8'h01) begin failures++; $display("FAIL setwins_head got=%h exp=01", word_data); end
        checks++; if (fill_level !== 3'd4) begin failures++; $display("FAIL setwins_fill got=%0d exp=4", fill_level); end
        // Holding with word_ready low keeps the head stable
        tick();
        checks++; if (word_data !== 8'h01) begin failures++; $display("FAIL hold_head got=%h exp=01", word_data); end
    endtask

    task automatic test_reset_midword();
        do_reset();
        send_word(8'h0A); send_word(8'h0B);
        send_bit(1); send_bit(1); send_bit(1);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b exp=0", word_valid); end
        checks++; if (word_data !== 8'h00) begin failures++; $display("FAIL mid_rst_data got=%h exp=00", word_data); end
        checks++; if (fill_level !== 3'd0) begin failures++; $display("FAIL mid_rst_fill got=%0d exp=0", fill_level); end
        valid_bit = 1'b1; output_bit = 1'b1; word_ready = 1'b1;
        tick(); tick();
        valid_bit = 1'b0; word_ready = 1'b0;
        checks++; if (fill_level !== 3'd0) begin failures++; $display("FAIL mid_rst_ignore got=%0d exp=0", fill_level); end
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) send_bit(1);
        checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL mid_partial_gone got=%b exp=0", word_valid); end
        send_bit(1);
        checks++; if (word_data !== 8'hFF) begin failures++; $display("FAIL mid_new_data got=%h exp=ff", word_data); end
        checks++; if (fill_level !== 3'd1) begin failures++; $display("FAIL mid_new_fill got=%0d exp=1", fill_level); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_flush();
        test_flush_coincide();
        test_overflow();
        test_full_push_pop();
        test_set_wins();
        test_reset_midword();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
